// File: rtl/axi_rw_arbiter.sv
// Round-robin arbiter granting a shared memory port to AXI write or read bursts.
// Registered outputs, sticky burst-timeout flag and wrapping completion counters.
module axi_rw_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 wr_done,
    input  logic                 rd_done,
    output logic                 wr_grant,
    output logic                 rd_grant,
    output logic                 aw_ready,
    output logic                 ar_ready,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 last_gnt
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_BUSY,
        RD_ADDR,
        RD_BUSY
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [15:0]          tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 err_q, err_d;
    logic                 wr_grant_q, wr_grant_d;
    logic                 rd_grant_q, rd_grant_d;
    logic                 aw_ready_q, aw_ready_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 tmo_hit;

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        // Port outputs trail the state by one register stage
        wr_grant_d = (state_q == WR_ADDR) || (state_q == WR_BUSY);
        rd_grant_d = (state_q == RD_ADDR) || (state_q == RD_BUSY);
        aw_ready_d = (state_q == WR_ADDR);
        ar_ready_d = (state_q == RD_ADDR);
        unique case (state_q)
            IDLE: begin
                if (wr_req && (!rd_req || last_gnt_q)) begin
                    state_d    = WR_ADDR;
                    last_gnt_d = 1'b0;
                end else if (rd_req) begin
                    state_d    = RD_ADDR;
                    last_gnt_d = 1'b1;
                end
            end
            WR_ADDR: begin
                state_d = WR_BUSY;
                tmo_d   = '0;
            end
            RD_ADDR: begin
                state_d = RD_BUSY;
                tmo_d   = '0;
            end
            WR_BUSY: begin
                // A completing done outranks a coincident timeout
                if (wr_done) begin
                    state_d  = IDLE;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RD_BUSY: begin
                if (rd_done) begin
                    state_d  = IDLE;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            aw_ready_q <= aw_ready_d;
            ar_ready_q <= ar_ready_d;
        end
    end

    assign wr_grant    = wr_grant_q;
    assign rd_grant    = rd_grant_q;
    assign aw_ready    = aw_ready_q;
    assign ar_ready    = ar_ready_q;
    assign timeout_err = err_q;
    assign wr_count    = wr_cnt_q;
    assign rd_count    = rd_cnt_q;
    assign last_gnt    = last_gnt_q;

endmodule
